multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/alu_dec.sv | 30 +++
 rtl/multicycle_ctrl.sv | 139 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, ALU and mux-select encodings for the multicycle controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - combinational data-processing decode: ALU operation, flag write enables, bad-opcode flag
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [4:0] funct,
  input  logic       cond_ex,
  output logic [3:0] alu_control,
  output logic [1:0] flag_w,
  output logic       bad_op
);

  logic arith;

  always_comb begin
    alu_control = ALU_ADD;
    bad_op      = 1'b0;
    arith       = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_control = ALU_ADD; arith = 1'b1; end
      4'b0010: begin alu_control = ALU_SUB; arith = 1'b1; end
      4'b0000: alu_control = ALU_AND;
      4'b1100: alu_control = ALU_ORR;
      4'b0001: alu_control = ALU_XOR;
      default: bad_op = 1'b1;
    endcase
    // C/V only make sense for arithmetic; an unknown code never writes them
    flag_w = cond_ex ? {funct[0], funct[0] & arith} : 2'b00;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle processor control FSM with memory-ready handshaking and sticky illegal flag
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t     state, state_next;
  logic [3:0] dec_alu;
  logic [1:0] dec_flag;
  logic       dec_bad;
  logic       is_exec;
  logic       ir_write, pc_write, reg_write, mem_write;
  logic [1:0] flag_write;

  alu_dec u_alu_dec (
    .funct       (Funct[4:0]),
    .cond_ex     (CondEx),
    .alu_control (dec_alu),
    .flag_w      (dec_flag),
    .bad_op      (dec_bad)
  );

  assign is_exec = (state == S_EXECR) || (state == S_EXECI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      // set on the edge into HALT so the flag is already visible while halted
      if ((state_next == S_HALT) || (is_exec && dec_bad))
        illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    flag_write = 2'b00;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        case (Op)
          2'b00:   state_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_next = S_MEMADR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_MEM;
        reg_write  = CondEx;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        mem_write = CondEx;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_REG;
        ALUControl = dec_alu;
        flag_write = dec_flag;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        // a write to R15 is a jump, not a register-file write
        if (Rd == 4'hF) pc_write  = CondEx;
        else            reg_write = CondEx;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALU;
        pc_write   = CondEx;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  assign IRWrite  = ir_write  & rst_n;
  assign PCWrite  = pc_write  & rst_n;
  assign RegWrite = reg_write & rst_n;
  assign MemWrite = mem_write & rst_n;
  assign FlagW    = flag_write & {2{rst_n}};
  assign state_o  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl: directed scenarios plus randomized instruction stream
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic       mem_ready;
  logic       IRWrite, AdrSrc, ALUSrcA, PCWrite, RegWrite, MemWrite, illegal;
  logic [1:0] ALUSrcB, ResultSrc, FlagW;
  logic [3:0] ALUControl, state_o;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
    .mem_ready(mem_ready), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl), .FlagW(FlagW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, adr, srca;
    logic [1:0] srcb, res;
    logic [3:0] aluc;
    logic [1:0] flagw;
    logic       pcw, regw, memw, ill;
  } exp_t;

  exp_t  expq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic  ill_m = 1'b0;
  int    idle_mode = -1;

  // scoreboard monitor: one expected vector per clock cycle
  always @(negedge clk) begin
    exp_t e, a;
    cyc++;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      a = {state_o, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW,
           PCWrite, RegWrite, MemWrite, illegal};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: actual st=%0d irw=%b adr=%b srca=%b srcb=%b res=%b aluc=%b flagw=%b pcw=%b regw=%b memw=%b ill=%b required st=%0d irw=%b adr=%b srca=%b srcb=%b res=%b aluc=%b flagw=%b pcw=%b regw=%b memw=%b ill=%b",
          cyc, a.st, a.irw, a.adr, a.srca, a.srcb, a.res, a.aluc, a.flagw, a.pcw, a.regw, a.memw, a.ill,
          e.st, e.irw, e.adr, e.srca, e.srcb, e.res, e.aluc, e.flagw, e.pcw, e.regw, e.memw, e.ill);
      end
    end
  end

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st  = st;
    e.ill = ill_m;
    return e;
  endfunction

  function automatic exp_t fetch_e(input logic mr);
    exp_t e;
    e = blank(S_FETCH);
    e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
    e.irw = mr; e.pcw = mr;
    return e;
  endfunction

  function automatic logic idle_mr();
    if (idle_mode < 0) return 1'($urandom_range(0, 1));
    return idle_mode[0];
  endfunction

  task automatic step(input logic mr, input exp_t e);
    mem_ready = mr;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input exp_t e);
    rst_n = 1'b0;
    step(1'($urandom_range(0, 1)), e);
    rst_n = 1'b1;
    ill_m = 1'b0;
  endtask

  // one instruction from fetch to return to FETCH, following the documented step sequence
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                           input logic cx, input int fetch_wait, input int mem_wait,
                           input int halt_cycles, input bit reset_in_memwr);
    exp_t e;
    logic [3:0] aluc;
    logic bad, arith;
    Op = op; Funct = fn; Rd = rd; CondEx = cx;
    for (int i = 0; i < fetch_wait; i++) step(1'b0, fetch_e(1'b0));
    step(1'b1, fetch_e(1'b1));
    e = blank(S_DECODE);
    e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
    step(idle_mr(), e);
    if (op == 2'b01) begin
      e = blank(S_MEMADR);
      e.srcb = 2'b01;
      step(idle_mr(), e);
      if (fn[0]) begin
        e = blank(S_MEMRD);
        e.adr = 1'b1;
        for (int i = 0; i < mem_wait; i++) step(1'b0, e);
        step(1'b1, e);
        e = blank(S_MEMWB);
        e.res = 2'b01; e.regw = cx;
        step(idle_mr(), e);
      end else begin
        e = blank(S_MEMWR);
        e.adr = 1'b1; e.memw = cx;
        for (int i = 0; i < mem_wait; i++) step(1'b0, e);
        if (reset_in_memwr) begin
          e.memw = 1'b0;
          reset_cycle(e);
        end else begin
          step(1'b1, e);
        end
      end
    end else if (op == 2'b00) begin
      bad = 1'b0; arith = 1'b0;
      case (fn[4:1])
        4'b0100: begin aluc = 4'd0; arith = 1'b1; end
        4'b0010: begin aluc = 4'd1; arith = 1'b1; end
        4'b0000: aluc = 4'd2;
        4'b1100: aluc = 4'd3;
        4'b0001: aluc = 4'd4;
        default: begin aluc = 4'd0; bad = 1'b1; end
      endcase
      e = blank(fn[5] ? S_EXECI : S_EXECR);
      e.srcb  = fn[5] ? 2'b01 : 2'b00;
      e.aluc  = aluc;
      e.flagw = cx ? {fn[0], fn[0] & arith} : 2'b00;
      step(idle_mr(), e);
      if (bad) ill_m = 1'b1;
      e = blank(S_ALUWB);
      if (rd == 4'hF) e.pcw = cx;
      else            e.regw = cx;
      step(idle_mr(), e);
    end else if (op == 2'b10) begin
      e = blank(S_BRANCH);
      e.srcb = 2'b01; e.res = 2'b10; e.pcw = cx;
      step(idle_mr(), e);
    end else begin
      ill_m = 1'b1;
      e = blank(S_HALT);
      for (int i = 0; i < halt_cycles; i++) step(idle_mr(), e);
      reset_cycle(e);
    end
  endtask

  logic [5:0] legal_fn [5];

  initial begin
    logic [5:0] fn;
    legal_fn[0] = 6'b001000; legal_fn[1] = 6'b000100; legal_fn[2] = 6'b000000;
    legal_fn[3] = 6'b011000; legal_fn[4] = 6'b000010;
    rst_n = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    // reset holds FETCH with strobes forced low even though mem_ready=1
    mem_ready = 1'b1;
    expq.push_back(fetch_e(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    idle_mode = 1;
    run_instr(2'b00, 6'b101001, 4'd1, 1'b1, 0, 0, 0, 1'b0);  // ADD R1,R2,#5 S=1
    idle_mode = -1;
    run_instr(2'b01, 6'b011001, 4'd3, 1'b1, 1, 3, 0, 1'b0);  // LDR, 3 wait cycles
    run_instr(2'b01, 6'b011000, 4'd3, 1'b0, 0, 2, 0, 1'b0);  // STR, CondEx=0
    run_instr(2'b10, 6'b000000, 4'd0, 1'b1, 0, 0, 0, 1'b0);  // B taken
    run_instr(2'b00, 6'b001000, 4'hF, 1'b1, 0, 0, 0, 1'b0);  // ADD PC,...
    run_instr(2'b00, 6'b000101, 4'd2, 1'b1, 0, 0, 0, 1'b0);  // SUBS reg
    run_instr(2'b00, 6'b011111, 4'd2, 1'b1, 0, 0, 0, 1'b0);  // unimplemented ALU code
    run_instr(2'b11, 6'b000000, 4'd0, 1'b1, 0, 0, 3, 1'b0);  // HALT then reset
    run_instr(2'b01, 6'b011000, 4'd4, 1'b1, 0, 2, 0, 1'b1);  // STR reset mid-hold
    run_instr(2'b10, 6'b000000, 4'd0, 1'b0, 2, 0, 0, 1'b0);  // B not taken

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) reset_cycle(fetch_e(1'b0));
      fn = ($urandom_range(0, 1) == 1) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) fn[5] = 1'($urandom);
      fn[0] = 1'($urandom);
      run_instr(2'($urandom_range(0, 3)), fn, 4'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
